// File: rtl/i2c_ctrl_pkg.sv
// Shared constants for the I2C request arbiter: FSM state codes and the
// default watchdog limit.
package i2c_ctrl_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARB    = 3'd1;
  localparam logic [2:0] LAUNCH = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam int TO_CYCLES_DEF = 4096;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches req starting one past ptr
// (wrapping) and returns the first asserted requester as one-hot and index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  int j;

  // First asserted request at ptr+1, ptr+2, ... ptr+NREQ (mod NREQ).
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(ptr_i) + i) % NREQ;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one single-transaction I2C master among NREQ requesters.
// Round-robin grant, payload latched at arbitration, watchdog-guarded wait,
// result returned only to the winner.
//
// state  | meaning
// IDLE   | no transaction, waiting for any request
// ARB    | pick winner, latch payload, issue launch pulse
// LAUNCH | m_start high for this cycle, watchdog starts
// WAIT   | waiting for m_done; aborts master when the watchdog expires
// RESP   | done pulse to the winner; grant drops on exit
module i2c_req_arbiter
  import i2c_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int N         = 7,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*N-1:0] req_addr,
  input  logic [NREQ-1:0] req_rw,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic [7:0]      rdata,
  output logic            nack,
  output logic            timeout,
  output logic            m_start,
  output logic [N-1:0]    m_addr,
  output logic            m_rw,
  output logic [7:0]      m_din,
  output logic            m_abort,
  input  logic            m_done,
  input  logic            m_nack,
  input  logic [7:0]      m_dout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TO_CYCLES + 1);

  logic [2:0]      state_q;
  logic [IW-1:0]   ptr_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic [7:0]      rdata_q;
  logic            nack_q;
  logic            timeout_q;
  logic            m_start_q;
  logic            m_abort_q;
  logic [N-1:0]    m_addr_q;
  logic            m_rw_q;
  logic [7:0]      m_din_q;
  logic [WW-1:0]   wd_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Sequencer: arbitration, launch, watchdog and response, all outputs registered.
  // The watchdog runs from LAUNCH, so it reads k at launch+k. Reaching
  // TO_CYCLES-1 raises m_abort for the next cycle; the following cycle
  // (watchdog saturated at TO_CYCLES) reports the timeout, so a late m_done
  // arriving while the master is being aborted is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NREQ - 1);
      grant_q   <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
      m_start_q <= 1'b0;
      m_abort_q <= 1'b0;
      m_addr_q  <= '0;
      m_rw_q    <= 1'b0;
      m_din_q   <= '0;
      wd_q      <= '0;
    end else begin
      done_q    <= '0;
      m_start_q <= 1'b0;
      m_abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) state_q <= ARB;
        end
        ARB: begin
          if (arb_valid) begin
            grant_q   <= arb_gnt;
            ptr_q     <= arb_idx;
            m_addr_q  <= req_addr[arb_idx*N +: N];
            m_rw_q    <= req_rw[arb_idx];
            m_din_q   <= req_wdata[arb_idx*8 +: 8];
            m_start_q <= 1'b1;
            wd_q      <= '0;
            state_q   <= LAUNCH;
          end else begin
            state_q <= IDLE;
          end
        end
        LAUNCH: begin
          wd_q    <= wd_q + WW'(1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (wd_q == WW'(TO_CYCLES)) begin
            done_q  <= grant_q;
            state_q <= RESP;
          end else if (m_done) begin
            done_q    <= grant_q;
            rdata_q   <= m_dout;
            nack_q    <= m_nack;
            timeout_q <= 1'b0;
            state_q   <= RESP;
          end else begin
            if (wd_q == WW'(TO_CYCLES - 1)) begin
              m_abort_q <= 1'b1;
              rdata_q   <= '0;
              nack_q    <= 1'b0;
              timeout_q <= 1'b1;
            end
            wd_q <= wd_q + WW'(1);
          end
        end
        RESP: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign nack    = nack_q;
  assign timeout = timeout_q;
  assign m_start = m_start_q;
  assign m_abort = m_abort_q;
  assign m_addr  = m_addr_q;
  assign m_rw    = m_rw_q;
  assign m_din   = m_din_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: directed cases plus randomized transactions,
// checked against a round-robin / timing reference model.
module tb_i2c_req_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 7;
  localparam int TO   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*N-1:0] req_addr = '0;
  logic [NREQ-1:0]   req_rw = '0;
  logic [NREQ*8-1:0] req_wdata = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [7:0]        rdata;
  logic              nack;
  logic              timeout;
  logic              m_start;
  logic [N-1:0]      m_addr;
  logic              m_rw;
  logic [7:0]        m_din;
  logic              m_abort;
  logic              m_done = 1'b0;
  logic              m_nack = 1'b0;
  logic [7:0]        m_dout = '0;

  int n_chk  = 0;
  int n_pass = 0;
  int last_win = NREQ - 1;

  i2c_req_arbiter #(.NREQ(NREQ), .N(N), .TO_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .req_wdata (req_wdata),
    .grant     (grant),
    .done      (done),
    .rdata     (rdata),
    .nack      (nack),
    .timeout   (timeout),
    .m_start   (m_start),
    .m_addr    (m_addr),
    .m_rw      (m_rw),
    .m_din     (m_din),
    .m_abort   (m_abort),
    .m_done    (m_done),
    .m_nack    (m_nack),
    .m_dout    (m_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] all_outs();
    return {28'd0, grant, done, rdata, nack, timeout, m_start, m_abort, m_addr, m_rw, m_din};
  endfunction

  // Reference: next requester after the last winner, in circular order.
  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last_win + k) % NREQ]) return (last_win + k) % NREQ;
    return -1;
  endfunction

  task automatic set_payload(input int i, input logic [N-1:0] a, input logic rw, input logic [7:0] wd);
    req_addr[i*N +: N] = a;
    req_rw[i]          = rw;
    req_wdata[i*8 +: 8] = wd;
  endtask

  task automatic scramble_payload();
    for (int i = 0; i < NREQ; i++)
      set_payload(i, N'($urandom), 1'($urandom), 8'($urandom));
  endtask

  // One transaction from IDLE. k < TO: master answers with m_done k cycles
  // after launch; otherwise the master stays silent and the watchdog fires.
  task automatic run_txn(input logic [NREQ-1:0] r, input int k, input bit hold,
                         input bit nk, input logic [7:0] dout);
    int w;
    logic [NREQ-1:0] oh;
    logic [N-1:0] ea;
    logic ew;
    logic [7:0] ed;
    req = r;
    w = model_pick(r);
    last_win = w;
    oh = NREQ'(1) << w;
    ea = req_addr[w*N +: N];
    ew = req_rw[w];
    ed = req_wdata[w*8 +: 8];
    @(negedge clk);
    check("grant_before_arb", 64'(grant), 64'(0));
    @(negedge clk);
    check("grant", 64'(grant), 64'(oh));
    check("m_start", 64'(m_start), 64'(1));
    check("launch_payload", {47'd0, m_addr, m_rw, m_din}, {47'd0, ea, ew, ed});
    if (!hold) req = '0;
    scramble_payload();
    if (k < TO) begin
      for (int c = 1; c <= k; c++) begin
        @(negedge clk);
        check("wait_quiet", {m_start, m_abort, done}, {2'b00, NREQ'(0)});
        check("payload_held", {47'd0, m_addr, m_rw, m_din}, {47'd0, ea, ew, ed});
      end
      m_done = 1'b1;
      m_nack = nk;
      m_dout = dout;
      @(negedge clk);
      m_done = 1'b0;
      m_nack = 1'($urandom);
      m_dout = 8'($urandom);
      check("done", 64'(done), 64'(oh));
      check("result", {rdata, nack, timeout, m_abort}, {dout, nk, 1'b0, 1'b0});
    end else begin
      for (int c = 1; c < TO; c++) begin
        @(negedge clk);
        check("no_early_abort", {m_abort, done}, {1'b0, NREQ'(0)});
      end
      @(negedge clk);
      check("abort", {m_abort, done}, {1'b1, NREQ'(0)});
      @(negedge clk);
      check("done_to", 64'(done), 64'(oh));
      check("result_to", {rdata, nack, timeout, m_abort}, {8'h00, 1'b0, 1'b1, 1'b0});
    end
    @(negedge clk);
    check("after_resp", {grant, done}, {NREQ'(0), NREQ'(0)});
  endtask

  initial begin
    scramble_payload();
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    set_payload(0, 7'h50, 1'b0, 8'hA5);
    run_txn(4'b0001, 5, 1'b0, 1'b0, 8'h00);

    set_payload(2, 7'h21, 1'b1, 8'h00);
    run_txn(4'b0100, 3, 1'b0, 1'b0, 8'h3C);

    for (int i = 0; i < 5; i++)
      run_txn(4'b1111, 2 + i, (i < 4), 1'b0, 8'($urandom));

    run_txn(4'b0010, 4, 1'b0, 1'b1, 8'h00);

    run_txn(4'b0001, TO + 4, 1'b0, 1'b0, 8'h00);
    run_txn(4'b0100, TO - 1, 1'b0, 1'b0, 8'h77);
    run_txn(4'b1000, TO, 1'b0, 1'b0, 8'h00);

    m_done = 1'b1;
    m_dout = 8'hEE;
    @(negedge clk);
    m_done = 1'b0;
    @(negedge clk);
    check("stray_m_done", {grant, done, m_start}, {NREQ'(0), NREQ'(0), 1'b0});

    for (int i = 0; i < 20; i++) begin
      scramble_payload();
      run_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(1, TO + 2),
              1'b0, 1'($urandom), 8'($urandom));
    end

    req = 4'b0001;
    repeat (5) @(negedge clk);
    req = '0;
    rst_n = 1'b0;
    #1;
    check("reset_mid_wait", all_outs(), 64'(0));
    repeat (2) @(negedge clk);
    check("reset_held", all_outs(), 64'(0));
    rst_n = 1'b1;
    last_win = NREQ - 1;
    @(negedge clk);
    check("post_reset_idle", {grant, done, m_abort}, {NREQ'(0), NREQ'(0), 1'b0});
    run_txn(4'b1000, 3, 1'b0, 1'b0, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
